// File: rtl/custom_logic_split_pkg.sv
// split_pkg: shared definitions for the custom_logic_split router.
//   route_tag_t  - destination encoded in the top two bits of every word
//   TAG_W        - width of the route tag
//   routes_to_a  - true when a tag delivers to branch A
//   routes_to_b  - true when a tag delivers to branch B
package split_pkg;

   localparam int unsigned TAG_W = 2;

   typedef enum logic [TAG_W-1:0] {
      ROUTE_A    = 2'b00,
      ROUTE_B    = 2'b01,
      ROUTE_BOTH = 2'b10,
      ROUTE_DROP = 2'b11
   } route_tag_t;

   function automatic logic routes_to_a(route_tag_t tag);
      return (tag == ROUTE_A) || (tag == ROUTE_BOTH);
   endfunction

   function automatic logic routes_to_b(route_tag_t tag);
      return (tag == ROUTE_B) || (tag == ROUTE_BOTH);
   endfunction

endpackage

// File: rtl/custom_logic_split_if.sv
// custom_logic_split_if: handshake bundle between the router and its neighbours.
//   up_data/up_valid/up_ready       - upstream word, tag in the two MSBs
//   down_data_x/valid_x/ready_x     - branch A and branch B outputs
//   drop_count                      - saturating count of discarded words
// Modports: slave = the router, master = whatever drives upstream and
// consumes both branches.
interface custom_logic_split_if #(
   parameter int unsigned D_WIDTH = 6,
   parameter int unsigned C_WIDTH = 8
);

   logic [D_WIDTH-1:0] up_data;
   logic               up_valid;
   logic               up_ready;
   logic [D_WIDTH-1:0] down_data_a;
   logic               down_valid_a;
   logic               down_ready_a;
   logic [D_WIDTH-1:0] down_data_b;
   logic               down_valid_b;
   logic               down_ready_b;
   logic [C_WIDTH-1:0] drop_count;

   modport slave (
      input  up_data, up_valid, down_ready_a, down_ready_b,
      output up_ready, down_data_a, down_valid_a, down_data_b, down_valid_b, drop_count
   );

   modport master (
      output up_data, up_valid, down_ready_a, down_ready_b,
      input  up_ready, down_data_a, down_valid_a, down_data_b, down_valid_b, drop_count
   );

endinterface

// File: rtl/custom_logic_split_skid_fifo2.sv
// skid_fifo2: two-entry FIFO feeding one router branch.
//   clk, rst          - clock, asynchronous active-high reset
//   wr_en, wr_data    - write side; caller only writes when full is low
//   full              - both entries occupied
//   down_data/valid   - head entry, driven straight from registers
//   down_ready        - consumer accepts the head this cycle
module skid_fifo2 #(
   parameter int unsigned D_WIDTH = 6
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               wr_en,
   input  logic [D_WIDTH-1:0] wr_data,
   output logic               full,
   output logic [D_WIDTH-1:0] down_data,
   output logic               down_valid,
   input  logic               down_ready
);

   logic [1:0]         count_q, count_d;
   logic [D_WIDTH-1:0] head_q, head_d;
   logic [D_WIDTH-1:0] tail_q, tail_d;
   logic               wr;
   logic               rd;

   assign full       = (count_q == 2'd2);
   assign down_valid = (count_q != 2'd0);
   assign down_data  = head_q;

   // Guard on full so a misbehaving caller cannot overwrite the tail.
   assign wr = wr_en & ~full;
   assign rd = down_valid & down_ready;

   always_comb begin
      count_d = count_q;
      head_d  = head_q;
      tail_d  = tail_q;
      case (count_q)
         2'd0: begin
            if (wr) begin
               head_d  = wr_data;
               count_d = 2'd1;
            end
         end
         2'd1: begin
            case ({wr, rd})
               // Head leaves while the new word takes its place: count stays 1.
               2'b11: head_d = wr_data;
               2'b01: count_d = 2'd0;
               2'b10: begin
                  tail_d  = wr_data;
                  count_d = 2'd2;
               end
               default: ;
            endcase
         end
         2'd2: begin
            if (rd) begin
               head_d  = tail_q;
               count_d = 2'd1;
            end
         end
         default: count_d = 2'd0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= 2'd0;
         head_q  <= '0;
         tail_q  <= '0;
      end else begin
         count_q <= count_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
      end
   end

endmodule

// File: rtl/custom_logic_split.sv
// custom_logic_split: routes each upstream word to branch A, branch B, both,
// or drops it, according to the two-bit tag in its MSBs. Each branch is
// buffered by a two-entry FIFO so the outputs are fully registered.
//   clk, rst  - clock, asynchronous active-high reset
//   bus       - slave side of custom_logic_split_if (upstream, both
//               branches and drop_count)
// D_WIDTH must be at least 3 so the word carries a payload beside the tag.
module custom_logic_split
   import split_pkg::*;
#(
   parameter int unsigned D_WIDTH = 6,
   parameter int unsigned C_WIDTH = 8
) (
   input logic                   clk,
   input logic                   rst,
   custom_logic_split_if.slave   bus
);

   route_tag_t         tag;
   logic               full_a;
   logic               full_b;
   logic               ready;
   logic               accept;
   logic               wr_a;
   logic               wr_b;
   logic [C_WIDTH-1:0] drop_q;

   assign tag = route_tag_t'(bus.up_data[D_WIDTH-1 -: TAG_W]);

   // Ready depends only on tag and occupancy, so downstream readiness never
   // reaches upstream combinationally. Broadcast waits for room in both.
   always_comb begin
      ready = 1'b0;
      unique case (tag)
         ROUTE_A:    ready = ~full_a;
         ROUTE_B:    ready = ~full_b;
         ROUTE_BOTH: ready = ~full_a & ~full_b;
         ROUTE_DROP: ready = 1'b1;
      endcase
   end

   assign bus.up_ready = ready;
   assign accept       = bus.up_valid & ready;
   assign wr_a         = accept & routes_to_a(tag);
   assign wr_b         = accept & routes_to_b(tag);

   skid_fifo2 #(
      .D_WIDTH (D_WIDTH)
   ) u_fifo_a (
      .clk        (clk),
      .rst        (rst),
      .wr_en      (wr_a),
      .wr_data    (bus.up_data),
      .full       (full_a),
      .down_data  (bus.down_data_a),
      .down_valid (bus.down_valid_a),
      .down_ready (bus.down_ready_a)
   );

   skid_fifo2 #(
      .D_WIDTH (D_WIDTH)
   ) u_fifo_b (
      .clk        (clk),
      .rst        (rst),
      .wr_en      (wr_b),
      .wr_data    (bus.up_data),
      .full       (full_b),
      .down_data  (bus.down_data_b),
      .down_valid (bus.down_valid_b),
      .down_ready (bus.down_ready_b)
   );

   // Saturating drop counter: holds at all-ones instead of wrapping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         drop_q <= '0;
      end else if (accept && (tag == ROUTE_DROP) && (drop_q != '1)) begin
         drop_q <= drop_q + C_WIDTH'(1);
      end
   end

   assign bus.drop_count = drop_q;

endmodule

// File: tb/tb_custom_logic_split.sv
// tb_custom_logic_split: directed vector table, reset corner case and a
// random-handshake scoreboard for custom_logic_split (D_WIDTH=6, C_WIDTH=2).
module tb_custom_logic_split;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   custom_logic_split_if #(.D_WIDTH(6), .C_WIDTH(2)) bus ();

   custom_logic_split #(
      .D_WIDTH (6),
      .C_WIDTH (2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [5:0] data;
      logic       valid;
      logic       ra;
      logic       rb;
      logic       ur;
      logic       va;
      logic [5:0] da;
      logic       vb;
      logic [5:0] db;
      logic [1:0] drop;
   } vec_t;

   vec_t vecs[27];

   function automatic vec_t mk(logic [5:0] data, logic valid, logic ra, logic rb, logic ur,
                               logic va, logic [5:0] da, logic vb, logic [5:0] db,
                               logic [1:0] drop);
      vec_t v;
      v.data = data; v.valid = valid; v.ra = ra; v.rb = rb; v.ur = ur;
      v.va = va; v.da = da; v.vb = vb; v.db = db; v.drop = drop;
      return v;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [5:0] data, input logic valid, input logic ra,
                        input logic rb);
      bus.up_data      = data;
      bus.up_valid     = valid;
      bus.down_ready_a = ra;
      bus.down_ready_b = rb;
   endtask

   // Scoreboard state for the random phase
   logic [5:0] qa[$];
   logic [5:0] qb[$];
   int         model_drop;
   int         accepted;
   int         seq;
   logic       prev_va, prev_ra, prev_vb, prev_rb;
   logic [5:0] prev_da, prev_db;

   task automatic rand_cycle(input bit allow_new);
      logic [1:0] tag;
      logic       exp_ur;
      logic [3:0] pay;
      tag = 2'($urandom_range(0, 3));
      pay = 4'(seq);
      drive({tag, pay}, allow_new && ($urandom_range(0, 3) != 0),
            $urandom_range(0, 3) != 0 || !allow_new, $urandom_range(0, 3) != 0 || !allow_new);
      #3;
      case (tag)
         2'b00:   exp_ur = qa.size() < 2;
         2'b01:   exp_ur = qb.size() < 2;
         2'b10:   exp_ur = (qa.size() < 2) && (qb.size() < 2);
         default: exp_ur = 1'b1;
      endcase
      chk("rand_up_ready", int'(bus.up_ready), int'(exp_ur));
      chk("rand_valid_a", int'(bus.down_valid_a), int'(qa.size() != 0));
      chk("rand_valid_b", int'(bus.down_valid_b), int'(qb.size() != 0));
      chk("rand_drop", int'(bus.drop_count), model_drop);
      if (bus.down_valid_a && qa.size() != 0) chk("rand_data_a", int'(bus.down_data_a), int'(qa[0]));
      if (bus.down_valid_b && qb.size() != 0) chk("rand_data_b", int'(bus.down_data_b), int'(qb[0]));
      if (prev_va && !prev_ra)
         chk("stable_a", int'({bus.down_valid_a, bus.down_data_a}), int'({1'b1, prev_da}));
      if (prev_vb && !prev_rb)
         chk("stable_b", int'({bus.down_valid_b, bus.down_data_b}), int'({1'b1, prev_db}));
      if (bus.down_valid_a && bus.down_ready_a && qa.size() != 0) void'(qa.pop_front());
      if (bus.down_valid_b && bus.down_ready_b && qb.size() != 0) void'(qb.pop_front());
      if (bus.up_valid && exp_ur) begin
         accepted++;
         seq++;
         if (tag == 2'b00 || tag == 2'b10) qa.push_back(bus.up_data);
         if (tag == 2'b01 || tag == 2'b10) qb.push_back(bus.up_data);
         if (tag == 2'b11 && model_drop < 3) model_drop++;
      end
      prev_va = bus.down_valid_a; prev_ra = bus.down_ready_a; prev_da = bus.down_data_a;
      prev_vb = bus.down_valid_b; prev_rb = bus.down_ready_b; prev_db = bus.down_data_b;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int cycles;
      checks   = 0;
      failures = 0;

      //            data   v  ra rb ur va da     vb db     drop
      vecs[0]  = mk(6'h05, 1, 1, 1, 1, 0, 6'h00, 0, 6'h00, 0);
      vecs[1]  = mk(6'h15, 1, 1, 1, 1, 1, 6'h05, 0, 6'h00, 0);
      vecs[2]  = mk(6'h00, 0, 1, 1, 1, 0, 6'h00, 1, 6'h15, 0);
      vecs[3]  = mk(6'h00, 0, 1, 1, 1, 0, 6'h00, 0, 6'h00, 0);
      vecs[4]  = mk(6'h01, 1, 0, 1, 1, 0, 6'h00, 0, 6'h00, 0);
      vecs[5]  = mk(6'h02, 1, 0, 1, 1, 1, 6'h01, 0, 6'h00, 0);
      vecs[6]  = mk(6'h03, 1, 0, 1, 0, 1, 6'h01, 0, 6'h00, 0);
      vecs[7]  = mk(6'h03, 1, 1, 1, 0, 1, 6'h01, 0, 6'h00, 0);
      vecs[8]  = mk(6'h03, 1, 1, 1, 1, 1, 6'h02, 0, 6'h00, 0);
      vecs[9]  = mk(6'h00, 0, 1, 1, 1, 1, 6'h03, 0, 6'h00, 0);
      vecs[10] = mk(6'h00, 0, 1, 1, 1, 0, 6'h00, 0, 6'h00, 0);
      vecs[11] = mk(6'h11, 1, 1, 0, 1, 0, 6'h00, 0, 6'h00, 0);
      vecs[12] = mk(6'h12, 1, 1, 0, 1, 0, 6'h00, 1, 6'h11, 0);
      vecs[13] = mk(6'h15, 0, 1, 0, 0, 0, 6'h00, 1, 6'h11, 0);
      vecs[14] = mk(6'h05, 0, 1, 0, 1, 0, 6'h00, 1, 6'h11, 0);
      vecs[15] = mk(6'h25, 1, 1, 0, 0, 0, 6'h00, 1, 6'h11, 0);
      vecs[16] = mk(6'h25, 1, 1, 1, 0, 0, 6'h00, 1, 6'h11, 0);
      vecs[17] = mk(6'h25, 1, 1, 0, 1, 0, 6'h00, 1, 6'h12, 0);
      vecs[18] = mk(6'h00, 0, 0, 1, 1, 1, 6'h25, 1, 6'h12, 0);
      vecs[19] = mk(6'h00, 0, 1, 1, 1, 1, 6'h25, 1, 6'h25, 0);
      vecs[20] = mk(6'h00, 0, 1, 1, 1, 0, 6'h00, 0, 6'h00, 0);
      vecs[21] = mk(6'h30, 1, 1, 1, 1, 0, 6'h00, 0, 6'h00, 0);
      vecs[22] = mk(6'h3F, 1, 1, 1, 1, 0, 6'h00, 0, 6'h00, 1);
      vecs[23] = mk(6'h31, 1, 1, 1, 1, 0, 6'h00, 0, 6'h00, 2);
      vecs[24] = mk(6'h32, 1, 1, 1, 1, 0, 6'h00, 0, 6'h00, 3);
      vecs[25] = mk(6'h33, 1, 1, 1, 1, 0, 6'h00, 0, 6'h00, 3);
      vecs[26] = mk(6'h00, 0, 1, 1, 1, 0, 6'h00, 0, 6'h00, 3);

      // Reset state
      rst = 1'b1;
      drive(6'h00, 1'b0, 1'b1, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid_a", int'(bus.down_valid_a), 0);
      chk("rst_valid_b", int'(bus.down_valid_b), 0);
      chk("rst_data_a", int'(bus.down_data_a), 0);
      chk("rst_data_b", int'(bus.down_data_b), 0);
      chk("rst_drop", int'(bus.drop_count), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Directed table; first row transfers on the first edge after release
      for (int i = 0; i < 27; i++) begin
         drive(vecs[i].data, vecs[i].valid, vecs[i].ra, vecs[i].rb);
         #3;
         chk($sformatf("v%0d_up_ready", i), int'(bus.up_ready), int'(vecs[i].ur));
         chk($sformatf("v%0d_valid_a", i), int'(bus.down_valid_a), int'(vecs[i].va));
         chk($sformatf("v%0d_valid_b", i), int'(bus.down_valid_b), int'(vecs[i].vb));
         chk($sformatf("v%0d_drop", i), int'(bus.drop_count), int'(vecs[i].drop));
         if (vecs[i].va) chk($sformatf("v%0d_data_a", i), int'(bus.down_data_a), int'(vecs[i].da));
         if (vecs[i].vb) chk($sformatf("v%0d_data_b", i), int'(bus.down_data_b), int'(vecs[i].db));
         @(posedge clk);
         #1;
      end

      // Reset mid-operation with two words held in A
      drive(6'h01, 1'b1, 1'b0, 1'b1);
      @(posedge clk);
      #1;
      drive(6'h02, 1'b1, 1'b0, 1'b1);
      @(posedge clk);
      #1;
      drive(6'h00, 1'b0, 1'b0, 1'b1);
      chk("pre_rst_valid_a", int'(bus.down_valid_a), 1);
      chk("pre_rst_data_a", int'(bus.down_data_a), 'h01);
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_valid_a", int'(bus.down_valid_a), 0);
      chk("async_rst_data_a", int'(bus.down_data_a), 0);
      chk("async_rst_drop", int'(bus.drop_count), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      drive(6'h0A, 1'b1, 1'b1, 1'b1);
      #3;
      chk("post_rst_up_ready", int'(bus.up_ready), 1);
      chk("post_rst_valid_a0", int'(bus.down_valid_a), 0);
      @(posedge clk);
      #1;
      drive(6'h00, 1'b0, 1'b1, 1'b1);
      #3;
      chk("post_rst_valid_a1", int'(bus.down_valid_a), 1);
      chk("post_rst_data_a1", int'(bus.down_data_a), 'h0A);
      chk("post_rst_valid_b1", int'(bus.down_valid_b), 0);
      @(posedge clk);
      #4;
      chk("post_rst_valid_a2", int'(bus.down_valid_a), 0);
      chk("post_rst_valid_b2", int'(bus.down_valid_b), 0);
      @(posedge clk);
      #1;

      // Random traffic against the scoreboard
      model_drop = 0;
      accepted   = 0;
      seq        = 0;
      prev_va = 1'b0; prev_ra = 1'b0; prev_vb = 1'b0; prev_rb = 1'b0;
      prev_da = '0;   prev_db = '0;
      cycles = 0;
      while (accepted < 10000 && cycles < 60000 && failures < 20) begin
         rand_cycle(1'b1);
         cycles++;
      end
      chk("rand_accepted", accepted, 10000);
      for (int i = 0; i < 6; i++) rand_cycle(1'b0);
      chk("drain_a_empty", qa.size(), 0);
      chk("drain_b_empty", qb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/custom_logic_split.md
CUSTOM_LOGIC_SPLIT -- requirements
Module: custom_logic_split

Interface
REQ-001 The block SHALL have parameter D_WIDTH, default 6, giving the data width in bits, with a legal minimum of 3.
REQ-002 The block SHALL have parameter C_WIDTH, default 8, giving the drop-counter width in bits.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 The block SHALL have port up_data, input, D_WIDTH bits: upstream word; bits [D_WIDTH-1:D_WIDTH-2] are the route tag.
REQ-006 The block SHALL have port up_valid, input, 1 bit: upstream word is present.
REQ-007 The block SHALL have port up_ready, output, 1 bit: block accepts the upstream word this cycle.
REQ-008 The block SHALL have port down_data_a, output, D_WIDTH bits: branch A data.
REQ-009 The block SHALL have port down_valid_a, output, 1 bit: branch A data is valid.
REQ-010 The block SHALL have port down_ready_a, input, 1 bit: branch A consumer is ready.
REQ-011 The block SHALL have ports down_data_b, down_valid_b and down_ready_b, identical to REQ-008 to REQ-010 for branch B.
REQ-012 The block SHALL have port drop_count, output, C_WIDTH bits: number of words discarded, saturating.

Function
REQ-013 A transfer SHALL occur on any port only in a cycle where its valid and ready are both high.
REQ-014 Once valid is asserted on an output, valid and data SHALL stay stable until the transfer occurs.
REQ-015 The route tag SHALL select the destination as follows:
- 00: branch A only.
- 01: branch B only.
- 10: broadcast to both A and B.
- 11: drop.
REQ-016 The full D_WIDTH-bit word, tag included, SHALL be forwarded unmodified.
REQ-017 Each branch SHALL contain a 2-entry FIFO buffer, and down_valid_x and down_data_x SHALL come directly from buffer registers, with no combinational path from any up_* signal.
REQ-018 up_ready SHALL be computed from the tag and buffer occupancy only, never from down_ready_x, as follows:
- tag 00: high when the A buffer is not full.
- tag 01: high when the B buffer is not full.
- tag 10: high only when both buffers are not full.
- tag 11: always high.
REQ-019 A broadcast word SHALL be written to both buffers in the same cycle; partial acceptance is forbidden.
REQ-020 Latency from upstream transfer to the word appearing on down_valid_x SHALL be exactly 1 cycle when the buffer was empty.
REQ-021 With down_ready_x held high, each branch SHALL sustain 1 word per cycle.
REQ-022 A simultaneous write and read on a full buffer SHALL NOT occur, because up_ready is low; a simultaneous write and read on a 1-entry buffer SHALL leave its count at 1.
REQ-023 Words SHALL leave each branch in their acceptance order.
REQ-024 Each accepted tag-11 word SHALL increment drop_count by 1, and drop_count SHALL saturate at 2^C_WIDTH-1 without wrapping.
REQ-025 When up_valid is low, up_ready SHALL still reflect the current tag value, but no state SHALL change.

Reset
REQ-026 While rst is high, all of the following SHALL hold:
- Both buffers are empty.
- down_valid_a = 0 and down_valid_b = 0.
- down_data_a = 0 and down_data_b = 0.
- drop_count = 0.
REQ-027 Reset asserted mid-operation SHALL discard buffered words immediately, and no word SHALL be presented after reset.
REQ-028 The first transfer SHALL be possible in the first clock edge after rst deasserts.

Structure
REQ-029 The tag encodings SHALL be defined in a shared package, split_pkg, as a typedef enum route_tag_t {ROUTE_A, ROUTE_B, ROUTE_BOTH, ROUTE_DROP}.
REQ-030 The branch buffer SHALL be one sub-module, skid_fifo2, parameterised by D_WIDTH, instantiated twice, and exposing full, wr_en, and the down-side handshake.
REQ-031 The block SHALL be fully synchronous apart from rst and SHALL contain no latches.

Verification
REQ-032 D_WIDTH=6: send 0x05 (tag 00), then 0x15 (tag 01), with both down_ready high -> down_data_a=0x05 one cycle later; down_data_b=0x15 one cycle after that.
REQ-033 down_ready_a=0: send three tag-00 words 0x01, 0x02, 0x03 -> first two accepted; up_ready=0 on the third; after down_ready_a=1 they emerge in order 0x01, 0x02, 0x03.
REQ-034 Fill the B buffer with 2 words, then send 0x25 (tag 10) -> up_ready=0 and nothing written to A; drain one B word -> 0x25 accepted into A and B in the same cycle.
REQ-035 C_WIDTH=2: send 5 tag-11 words -> up_ready=1 each cycle; drop_count reads 1, 2, 3, 3, 3; no down_valid asserted.
REQ-036 Assert rst while 2 words sit in buffer A -> down_valid_a=0 asynchronously; after release, a new word 0x0A appears on A alone.
REQ-037 Random valid/ready with a scoreboard over 10000 words -> no loss, no duplication except for broadcasts, per-branch order preserved, stability rule held.
